// File: rtl/fifo_burst_writer.sv
// Burst writer: latches len/mode/seed on start and writes len pattern words into a FIFO, one word per 2 cycles unstalled.
// First strobe the cycle after start; fifo_full stalls the strobe, a missing ack times out, overflow aborts.
module fifo_burst_writer #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [LEN_W-1:0]  words_written,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    input  logic              fifo_wr_ack,
    input  logic              fifo_overflow
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic [LEN_W-1:0]   words_q, words_d;
    logic [1:0]         err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [LEN_W-1:0]   words_inc;

    assign words_inc = words_q + LEN_W'(1);

    // Word k of the pattern; the acked-word count doubles as the word index.
    function automatic logic [DATA_W-1:0] gen_word(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [LEN_W-1:0] k);
        logic [DATA_W-1:0] k_ext;
        k_ext = DATA_W'(k);
        case (m)
            2'd0:    gen_word = s;
            2'd1:    gen_word = s + k_ext;
            2'd2:    gen_word = s - k_ext;
            default: gen_word = k[0] ? ~s : s;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
            words_q <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            words_q <= words_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        words_d    = words_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        din_d      = din_q;
        fifo_wr_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    mode_d  = mode;
                    seed_d  = seed;
                    words_d = '0;
                    tmo_d   = '0;
                    din_d   = seed;
                    if (len == '0) begin
                        err_d   = 2'd3;
                        state_d = S_ERROR;
                    end else begin
                        err_d   = 2'd0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                fifo_wr_en = !fifo_full;
                if (fifo_overflow) begin
                    err_d   = 2'd1;
                    state_d = S_ERROR;
                end else if (!fifo_full) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Overflow wins over a simultaneous ack: the word is not counted.
                if (fifo_overflow) begin
                    err_d   = 2'd1;
                    state_d = S_ERROR;
                end else if (fifo_wr_ack) begin
                    words_d = words_inc;
                    din_d   = gen_word(mode_q, seed_q, words_inc);
                    state_d = (words_inc == len_q) ? S_DONE : S_WRITE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        err_d   = 2'd2;
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign err_code      = err_q;
    assign words_written = words_q;
    assign fifo_din      = din_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: table of directed bursts plus random bursts, each checked against a burst-level model.
module tb_fifo_burst_writer;
    localparam int DATA_W      = 8;
    localparam int LEN_W       = 5;
    localparam int ACK_TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [LEN_W-1:0]  words_written;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full, fifo_wr_ack, fifo_overflow;

    fifo_burst_writer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .words_written(words_written), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int len;
        int mode;
        int seed;
        int stall_from;   // first cycle of a forced fifo_full window
        int stall_n;
        int noack_word;   // strobe index that never gets acked (-1 none)
        int ovf_word;     // strobe index whose ack cycle carries overflow (-1 none)
        int restart_cyc;  // cycle to pulse a second start while busy (-1 none)
        int reset_cyc;    // cycle to assert reset mid-burst (-1 none)
        bit rnd_full;
        int exp_err;
        int exp_words;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int l, int m, int s, int sf, int sn, int na, int ov,
                                int rs, int rc, bit rf, int ee, int ew);
        vec_t v;
        v.len = l; v.mode = m; v.seed = s; v.stall_from = sf; v.stall_n = sn;
        v.noack_word = na; v.ovf_word = ov; v.restart_cyc = rs; v.reset_cyc = rc;
        v.rnd_full = rf; v.exp_err = ee; v.exp_words = ew;
        return v;
    endfunction

    function automatic int model_word(int m, int s, int k);
        case (m)
            0:       return s;
            1:       return (s + k) % 256;
            2:       return (s - k + 256 * 32) % 256;
            default: return (k % 2 == 1) ? (255 - s) : s;
        endcase
    endfunction

    // Walk the words in order: the first one that overflows or is never acked ends the burst.
    task automatic model_outcome(input vec_t v, output int err, output int words);
        err = 0;
        words = v.len;
        if (v.len == 0) begin
            err = 3;
            words = 0;
            return;
        end
        for (int k = 0; k < v.len; k++) begin
            if (k == v.ovf_word)   begin err = 1; words = k; return; end
            if (k == v.noack_word) begin err = 2; words = k; return; end
        end
    endtask

    task automatic run_burst(input string tag, input vec_t v);
        int strobes = 0, last_strobe = -1, prev_idx = -1;
        int done_n = 0, err_n = 0, done_cyc = -1, err_cyc = -1, full_viol = 0;
        int exp_strobes;
        bit prev_strobe = 1'b0, fin = 1'b0, was_reset = 1'b0;
        int din_q[$];
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            start = (cyc == 0) || (cyc == v.restart_cyc);
            if (cyc == 0) begin
                len = LEN_W'(v.len); mode = 2'(v.mode); seed = DATA_W'(v.seed);
            end else if (cyc == v.restart_cyc) begin
                len = 5'd7; mode = 2'd1; seed = 8'h11;
            end
            reset         = (cyc == v.reset_cyc);
            fifo_full     = (cyc >= v.stall_from && cyc < v.stall_from + v.stall_n) ||
                            (v.rnd_full && $urandom_range(0, 3) == 0);
            fifo_wr_ack   = prev_strobe && (prev_idx != v.noack_word);
            fifo_overflow = prev_strobe && (prev_idx == v.ovf_word);
            #1;
            if (v.reset_cyc >= 0 && cyc == v.reset_cyc + 1) begin
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                check({tag, "_rst_error"}, error, 0);
                check({tag, "_rst_wr_en"}, fifo_wr_en, 0);
                check({tag, "_rst_err_code"}, err_code, 0);
                check({tag, "_rst_words"}, words_written, 0);
                check({tag, "_rst_din"}, fifo_din, 0);
                was_reset = 1'b1;
                fin = 1'b1;
            end else begin
                if (fifo_wr_en) begin
                    if (fifo_full) full_viol++;
                    din_q.push_back(int'(fifo_din));
                    strobes++;
                    last_strobe = cyc;
                end
                prev_strobe = fifo_wr_en;
                prev_idx = strobes - 1;
                if (done)  begin done_n++; done_cyc = cyc; end
                if (error) begin err_n++;  err_cyc = cyc;  end
                if (cyc > 0 && !busy) fin = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; reset = 1'b0; fifo_full = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
        check({tag, "_finished"}, fin, 1);
        if (was_reset || !fin) return;
        exp_strobes = (v.exp_err == 3) ? 0 : (v.exp_err == 0) ? v.len : v.exp_words + 1;
        check({tag, "_strobes"}, strobes, exp_strobes);
        foreach (din_q[i]) check({tag, "_din"}, din_q[i], model_word(v.mode, v.seed, i));
        check({tag, "_done_pulses"}, done_n, (v.exp_err == 0) ? 1 : 0);
        check({tag, "_error_pulses"}, err_n, (v.exp_err != 0) ? 1 : 0);
        check({tag, "_err_code"}, err_code, v.exp_err);
        check({tag, "_words"}, words_written, v.exp_words);
        check({tag, "_strobe_while_full"}, full_viol, 0);
        if (v.exp_err == 0 && !v.rnd_full && v.stall_n == 0)
            check({tag, "_done_latency"}, done_cyc, 2 * v.len + 1);
        if (v.exp_err == 2) check({tag, "_timeout_latency"}, err_cyc - last_strobe, ACK_TIMEOUT + 1);
        if (v.exp_err == 1) check({tag, "_ovf_latency"}, err_cyc - last_strobe, 2);
        if (v.exp_err == 3) check({tag, "_len0_latency"}, err_cyc, 1);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(4,  1, 'hFE, -1, 0, -1, -1, -1, -1, 0, 0, 4);
        tbl[1] = mk(3,  3, 'hA5,  3, 5, -1, -1, -1, -1, 0, 0, 3);
        tbl[2] = mk(5,  0, 'h3C, -1, 0,  1, -1, -1, -1, 0, 2, 1);
        tbl[3] = mk(6,  1, 'h10, -1, 0, -1,  2, -1, -1, 0, 1, 2);
        tbl[4] = mk(0,  0, 'h55, -1, 0, -1, -1, -1, -1, 0, 3, 0);
        tbl[5] = mk(2,  2, 'h01, -1, 0, -1, -1, -1, -1, 0, 0, 2);
        tbl[6] = mk(31, 2, 'h00, -1, 0, -1, -1, -1, -1, 1, 0, 31);
        tbl[7] = mk(5,  1, 'h20, -1, 0, -1, -1, -1,  6, 0, 0, 0);
        tbl[8] = mk(3,  0, 'h77, -1, 0, -1, -1,  2, -1, 0, 0, 3);
        tbl[9] = mk(1,  3, 'hC3, -1, 0,  0,  0, -1, -1, 0, 1, 0);

        reset = 1'b1; start = 1'b0; len = '0; mode = '0; seed = '0;
        fifo_full = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_wr_en", fifo_wr_en, 0);
        check("reset_err_code", err_code, 0);
        check("reset_words", words_written, 0);
        check("reset_din", fifo_din, 0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_burst($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
        end

        for (int i = 0; i < 25; i++) begin
            vec_t v;
            int e, w;
            v = mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                   -1, 0, -1, -1, -1, -1, 1'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 3) == 0) v.noack_word = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) v.ovf_word   = int'($urandom_range(0, 31));
            model_outcome(v, e, w);
            v.exp_err = e;
            v.exp_words = w;
            run_burst($sformatf("rnd%0d", i), v);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
